// File: rtl/fetch_unit_pkg.sv
// Shared front-end constants: fetch FSM encoding, boot PC, instruction width,
// and the buffered instruction entry layout.
package fetch_unit_pkg;

  localparam int          ILEN         = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO (power-of-two depth) with flush; used both as the
// instruction buffer and as the in-flight PC tag queue.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches, buffers in-order responses
// for decode and discards responses made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int            CW      = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(FIFO_DEPTH);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [CW-1:0] outstanding, out_nxt, drop_cnt, drop_nxt;

  logic          req_acc, push_inst;
  ibuf_entry_t   ibuf_din, ibuf_dout;
  logic [CW-1:0] ibuf_count, tag_count;
  logic          ibuf_empty, ibuf_full, tag_empty, tag_full;
  logic [31:0]   tag_dout;

  // Credit check counts buffered plus in-flight so every response has a slot.
  assign imem_req_valid = (state == S_FETCH) &&
                          (({1'b0, ibuf_count} + {1'b0, outstanding}) < DEPTH_X);
  assign imem_req_addr  = pc;
  assign req_acc        = imem_req_valid & imem_req_ready;
  assign out_nxt        = outstanding + CW'(req_acc) - CW'(imem_resp_valid);
  assign push_inst      = imem_resp_valid & ~redirect_valid & (drop_cnt == '0);

  assign ibuf_din   = '{pc: tag_dout, inst: imem_resp_data};
  assign inst_valid = ~ibuf_empty;
  assign inst       = ibuf_dout.inst;
  assign inst_pc    = ibuf_dout.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ibuf_entry_t))) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_inst),
    .din   (ibuf_din),
    .pop   (inst_valid & inst_ready),
    .flush (redirect_valid),
    .dout  (ibuf_dout),
    .count (ibuf_count),
    .empty (ibuf_empty),
    .full  (ibuf_full)
  );

  // Tags are popped by every response, dropped or not, so they stay aligned.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_acc),
    .din   (pc),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .dout  (tag_dout),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop_cnt;
    if (redirect_valid) begin
      // Everything still in flight after this edge is stale.
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      drop_nxt  = out_nxt;
      state_nxt = (out_nxt == '0) ? S_FETCH : S_DRAIN;
    end else begin
      case (state)
        S_BOOT:  state_nxt = S_FETCH;
        S_FETCH: if (req_acc) pc_nxt = pc + 32'd4;
        S_DRAIN: begin
          if (imem_resp_valid && drop_cnt != '0) drop_nxt = drop_cnt - CW'(1);
          if (drop_nxt == '0) state_nxt = S_FETCH;
        end
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  a_out_max:  assert property (@(posedge clk) disable iff (!rst_n)
                {1'b0, outstanding} <= DEPTH_X);
  a_drop_le:  assert property (@(posedge clk) disable iff (!rst_n)
                drop_cnt <= outstanding);
  a_ibuf_ovf: assert property (@(posedge clk) disable iff (!rst_n)
                !(push_inst && ibuf_full));
  a_resp_orp: assert property (@(posedge clk) disable iff (!rst_n)
                !(imem_resp_valid && (outstanding == '0 || tag_empty)));
  a_tag_sync: assert property (@(posedge clk) disable iff (!rst_n)
                (tag_count == outstanding) && !(req_acc && tag_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with fixed latency,
// decode/request monitors, hand-computed expectations.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } rec_t;
  typedef struct packed { logic [31:0] addr; int due; } mreq_t;

  rec_t        got_q[$];
  logic [31:0] req_q[$];
  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0200) return NOP;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: accept sampled on the edge, response driven just after it.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) mq.delete();
    else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_q.push_back(imem_req_addr);
    end
    #1;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_f(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  always @(posedge clk)
    if (rst_n && inst_valid && inst_ready) got_q.push_back('{pc: inst_pc, ins: inst});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] got_pc(input int i);
    return (i < got_q.size()) ? got_q[i].pc : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] got_ins(input int i);
    return (i < got_q.size()) ? got_q[i].ins : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    req_q.delete();
  endtask

  // Redirect sampled on the next edge; returns on the negedge after it.
  task automatic redir(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
    got_q.delete();
    req_q.delete();
  endtask

  initial begin
    // Reset values and boot cycle
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr",  imem_req_addr,       32'h0);
    chk("rst_inst_valid", 32'(inst_valid),    32'h0);
    chk("rst_inst",      inst,                32'h0);
    chk("rst_inst_pc",   inst_pc,             32'h0);
    rst_n = 1'b1;
    chk("boot_no_req",   32'(imem_req_valid), 32'h0);
    cycles(1);
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr",  imem_req_addr,       32'h0);

    // Streaming, latency 1
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    cycles(20);
    chk("stream_pc0", got_pc(0), 32'h0000_0000);
    chk("stream_pc1", got_pc(1), 32'h0000_0004);
    chk("stream_pc2", got_pc(2), 32'h0000_0008);
    chk("stream_pc3", got_pc(3), 32'h0000_000C);
    chk("stream_ins0", got_ins(0), 32'hA5A5_0000);
    chk("stream_ins3", got_ins(3), 32'hA5A5_000C);

    // Decode stall: buffer fills, issue stops, nothing lost on resume
    inst_ready = 1'b0;
    do_reset();
    cycles(10);
    chk("stall_req_count", 32'(req_q.size()), 32'd2);
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall_inst_valid", 32'(inst_valid), 32'h1);
    chk("stall_inst_pc", inst_pc, 32'h0);
    chk("stall_inst", inst, 32'hA5A5_0000);
    inst_ready = 1'b1;
    cycles(20);
    chk("resume_pc0", got_pc(0), 32'h0);
    chk("resume_pc1", got_pc(1), 32'h4);
    chk("resume_pc2", got_pc(2), 32'h8);
    chk("resume_pc3", got_pc(3), 32'hC);

    // Redirect with two outstanding, latency 3
    lat = 3;
    do_reset();
    cycles(3);
    chk("rd1_outstanding", 32'(req_q.size()), 32'd2);
    redir(32'h0000_0100);
    cycles(1);
    chk("rd1_drain_no_req", 32'(imem_req_valid), 32'h0);
    cycles(1);
    chk("rd1_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rd1_req_addr", imem_req_addr, 32'h0000_0100);
    cycles(12);
    chk("rd1_first_req", req_at(0), 32'h0000_0100);
    chk("rd1_first_pc", got_pc(0), 32'h0000_0100);
    chk("rd1_first_ins", got_ins(0), 32'hA5A5_0100);

    // Redirect to unaligned target while idle and empty
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset();
    cycles(3);
    chk("idle_hold_addr", imem_req_addr, 32'h0);
    redir(32'h0000_0203);
    chk("rd2_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rd2_req_addr", imem_req_addr, 32'h0000_0200);
    imem_req_ready = 1'b1;
    cycles(10);
    chk("rd2_first_pc", got_pc(0), 32'h0000_0200);
    chk("rd2_first_ins", got_ins(0), NOP);

    // Redirect coinciding with response and pop, then redirect during drain
    lat = 3;
    do_reset();
    cycles(5);
    chk("co_inst_valid", 32'(inst_valid), 32'h1);
    chk("co_inst_pc", inst_pc, 32'h0);
    chk("co_resp_valid", 32'(imem_resp_valid), 32'h1);
    redir(32'h0000_0080);
    chk("co_flushed", 32'(inst_valid), 32'h0);
    chk("co_req_addr", imem_req_addr, 32'h0000_0080);
    cycles(2);
    redir(32'h0000_0300);
    redir(32'h0000_0040);
    chk("dd_drain_no_req", 32'(imem_req_valid), 32'h0);
    cycles(1);
    chk("dd_req_valid", 32'(imem_req_valid), 32'h1);
    chk("dd_req_addr", imem_req_addr, 32'h0000_0040);
    cycles(12);
    chk("dd_first_pc", got_pc(0), 32'h0000_0040);
    chk("dd_first_ins", got_ins(0), 32'hA5A5_0040);

    // PC wrap
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset();
    cycles(2);
    redir(32'hFFFF_FFFC);
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    cycles(1);
    chk("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
    cycles(8);
    chk("wrap_pc0", got_pc(0), 32'hFFFF_FFFC);
    chk("wrap_pc1", got_pc(1), 32'h0000_0000);
    chk("wrap_ins0", got_ins(0), 32'h5A5A_FFFC);

    // Asynchronous reset in the middle of a drain
    lat = 3;
    inst_ready = 1'b0;
    do_reset();
    cycles(6);
    inst_ready = 1'b1;
    cycles(3);
    redir(32'h0000_0500);
    chk("mr_drain_no_req", 32'(imem_req_valid), 32'h0);
    chk("mr_pre_addr", imem_req_addr, 32'h0000_0500);
    rst_n = 1'b0;
    #1;
    chk("mr_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mr_req_addr", imem_req_addr, 32'h0);
    chk("mr_inst_valid", 32'(inst_valid), 32'h0);
    chk("mr_inst", inst, 32'h0);
    chk("mr_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    req_q.delete();
    cycles(1);
    chk("mr_restart_addr", imem_req_addr, 32'h0);
    cycles(10);
    chk("mr_restart_pc0", got_pc(0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
